tdc_measure_ctrl: RTL and testbench

TDC_MEASURE_CTRL -- requirements
Module: tdc_measure_ctrl

---
 rtl/tdc_pkg.sv | 31 +++
 rtl/tdc_therm_popcount.sv | 40 ++++
 rtl/tdc_measure_ctrl.sv | 160 ++++++++++++++++
 tb/tb_tdc_measure_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// -----------------------------------------------------------------------------
// tdc_pkg
// Shared definitions for the TDC measurement controller:
//   - default geometry (NTAPS, CW, TIMEOUT)
//   - fine-code width derivation (FW = clog2(NTAPS+1))
//   - controller FSM state enumeration
// -----------------------------------------------------------------------------
package tdc_pkg;

    // 16 CARRY4 stages x 4 taps each
    localparam int NTAPS_DEFAULT   = 64;
    localparam int CW_DEFAULT      = 16;
    localparam int TIMEOUT_DEFAULT = 1000;

    // The fine code must be able to represent every count 0..NTAPS inclusive,
    // which is why the width is derived from NTAPS+1 rather than NTAPS.
    function automatic int fine_width(input int ntaps);
        return $clog2(ntaps + 1);
    endfunction

    localparam int FW_DEFAULT = fine_width(NTAPS_DEFAULT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_ENCODE = 3'd2,
        ST_OUTPUT = 3'd3,
        ST_CLEAR  = 3'd4
    } tdc_state_e;

endpackage

// File: rtl/tdc_therm_popcount.sv
// -----------------------------------------------------------------------------
// tdc_therm_popcount
// Purely combinational ones-counter for a captured delay-line thermometer.
// Every set bit counts individually, so bubbles (non-contiguous ones caused
// by tap skew) still produce a sensible fine code.
//
// Ports
//   therm_i  in  NTAPS  captured thermometer sample
//   count_o  out FW     number of ones in therm_i (0..NTAPS)
// -----------------------------------------------------------------------------
module tdc_therm_popcount
    import tdc_pkg::*;
#(
    parameter  int NTAPS = NTAPS_DEFAULT,
    localparam int FW    = fine_width(NTAPS)
) (
    input  logic [NTAPS-1:0] therm_i,
    output logic [FW-1:0]    count_o
);

    // Widen each tap to the result width once, so the adder chain below is
    // a uniform FW-bit sum.
    logic [FW-1:0] bit_ext [NTAPS];

    for (genvar gi = 0; gi < NTAPS; gi++) begin : g_ext
        assign bit_ext[gi] = FW'(therm_i[gi]);
    end

    logic [FW-1:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < NTAPS; i++) begin
            sum = sum + bit_ext[i];
        end
    end

    assign count_o = sum;

endmodule

// File: rtl/tdc_measure_ctrl.sv
// -----------------------------------------------------------------------------
// tdc_measure_ctrl
// Measurement controller for a carry-chain TDC. After an arm request it runs
// a coarse counter until the registered delay-line sample shows a hit on tap
// 0, captures the thermometer, encodes it into a fine code, presents the
// timestamp on a valid/ready interface and finally drains the delay line
// before accepting the next arm.
//
// Ports
//   clk         in   1      system clock (rising edge)
//   rst         in   1      synchronous active-high reset
//   arm         in   1      start request, honoured only in IDLE
//   tap_q       in   NTAPS  registered thermometer sample (bit 0 nearest CI)
//   line_clr    out  1      holds the delay-line launch input low (CLEAR)
//   busy        out  1      controller not idle
//   ts_valid    out  1      timestamp available
//   ts_ready    in   1      consumer accepts timestamp
//   ts_coarse   out  CW     coarse count at hit (TIMEOUT on timeout)
//   ts_fine     out  FW     ones count of captured thermometer
//   ts_timeout  out  1      measurement ended without a hit
//
// TIMEOUT must lie in 1 .. 2**CW-1.
// -----------------------------------------------------------------------------
module tdc_measure_ctrl
    import tdc_pkg::*;
#(
    parameter  int NTAPS   = NTAPS_DEFAULT,
    parameter  int CW      = CW_DEFAULT,
    parameter  int TIMEOUT = TIMEOUT_DEFAULT,
    localparam int FW      = fine_width(NTAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic [NTAPS-1:0] tap_q,
    output logic             line_clr,
    output logic             busy,
    output logic             ts_valid,
    input  logic             ts_ready,
    output logic [CW-1:0]    ts_coarse,
    output logic [FW-1:0]    ts_fine,
    output logic             ts_timeout
);

    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    tdc_state_e       state_q,      state_d;
    logic [CW-1:0]    coarse_q,     coarse_d;
    logic [NTAPS-1:0] cap_q,        cap_d;
    logic [CW-1:0]    ts_coarse_q,  ts_coarse_d;
    logic [FW-1:0]    ts_fine_q,    ts_fine_d;
    logic             ts_timeout_q, ts_timeout_d;
    // Set once one all-zero CLEAR cycle has been seen; a second consecutive
    // zero cycle then releases the controller back to IDLE.
    logic             zero_seen_q,  zero_seen_d;

    logic [FW-1:0]    enc_count;

    // Encoding works from the capture register, not from tap_q, so the
    // delay line is free to keep moving during ENCODE.
    tdc_therm_popcount #(
        .NTAPS (NTAPS)
    ) u_popcount (
        .therm_i (cap_q),
        .count_o (enc_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            coarse_q     <= '0;
            cap_q        <= '0;
            ts_coarse_q  <= '0;
            ts_fine_q    <= '0;
            ts_timeout_q <= 1'b0;
            zero_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            coarse_q     <= coarse_d;
            cap_q        <= cap_d;
            ts_coarse_q  <= ts_coarse_d;
            ts_fine_q    <= ts_fine_d;
            ts_timeout_q <= ts_timeout_d;
            zero_seen_q  <= zero_seen_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        coarse_d     = coarse_q;
        cap_d        = cap_q;
        ts_coarse_d  = ts_coarse_q;
        ts_fine_d    = ts_fine_q;
        ts_timeout_d = ts_timeout_q;
        zero_seen_d  = zero_seen_q;

        unique case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d  = ST_ARMED;
                    coarse_d = '0;
                end
            end

            ST_ARMED: begin
                // Counter saturates at TIMEOUT so it can never wrap.
                if (coarse_q != TIMEOUT_C) begin
                    coarse_d = coarse_q + CW'(1);
                end
                // Hit is tested first so a hit on the timeout cycle wins.
                if (tap_q[0]) begin
                    cap_d       = tap_q;
                    ts_coarse_d = coarse_q;
                    state_d     = ST_ENCODE;
                end else if (coarse_q == TIMEOUT_C) begin
                    ts_coarse_d  = TIMEOUT_C;
                    ts_fine_d    = '0;
                    ts_timeout_d = 1'b1;
                    state_d      = ST_OUTPUT;
                end
            end

            ST_ENCODE: begin
                ts_fine_d    = enc_count;
                ts_timeout_d = 1'b0;
                state_d      = ST_OUTPUT;
            end

            ST_OUTPUT: begin
                if (ts_ready) begin
                    state_d     = ST_CLEAR;
                    zero_seen_d = 1'b0;
                end
            end

            ST_CLEAR: begin
                if (|tap_q) begin
                    zero_seen_d = 1'b0;
                end else if (zero_seen_q) begin
                    zero_seen_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    zero_seen_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign ts_valid   = (state_q == ST_OUTPUT);
    assign line_clr   = (state_q == ST_CLEAR);
    assign ts_coarse  = ts_coarse_q;
    assign ts_fine    = ts_fine_q;
    assign ts_timeout = ts_timeout_q;

endmodule

// File: tb/tb_tdc_measure_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tdc_measure_ctrl
// Self-checking bench for tdc_measure_ctrl (NTAPS=64, CW=16, TIMEOUT=10).
// A table of directed measurements is followed by randomized measurements
// whose expectations come from a transaction-level model, plus hand-written
// reset sequences.
// -----------------------------------------------------------------------------
module tb_tdc_measure_ctrl;

    localparam int NTAPS = 64;
    localparam int CW    = 16;
    localparam int TMO   = 10;
    localparam int FW    = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic             arm;
    logic [NTAPS-1:0] tap_q;
    logic             line_clr;
    logic             busy;
    logic             ts_valid;
    logic             ts_ready;
    logic [CW-1:0]    ts_coarse;
    logic [FW-1:0]    ts_fine;
    logic             ts_timeout;

    int n_cmp = 0;
    int n_err = 0;

    tdc_measure_ctrl #(
        .NTAPS   (NTAPS),
        .CW      (CW),
        .TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .tap_q      (tap_q),
        .line_clr   (line_clr),
        .busy       (busy),
        .ts_valid   (ts_valid),
        .ts_ready   (ts_ready),
        .ts_coarse  (ts_coarse),
        .ts_fine    (ts_fine),
        .ts_timeout (ts_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},     busy,       0);
        check({tag, "_valid"},    ts_valid,   0);
        check({tag, "_coarse"},   ts_coarse,  0);
        check({tag, "_fine"},     ts_fine,    0);
        check({tag, "_timeout"},  ts_timeout, 0);
        check({tag, "_line_clr"}, line_clr,   0);
    endtask

    // One complete measurement: arm, present a hit (tap pattern on ARMED
    // cycle k, cycle 0 being the first ARMED cycle) or none, hold ts_ready
    // low for d OUTPUT cycles, then keep the line non-empty for nz CLEAR
    // cycles. Stray arm pulses are injected where they must be ignored.
    task automatic measure(input string tag, input logic [63:0] pat, input int k,
                           input int d, input int nz, input int ec, input int ef,
                           input bit eto, input int elat);
        int c;
        logic [63:0] junk;

        check({tag, "_idle_before"}, busy, 0);
        arm = 1'b1;
        tap_q = '0;
        tick();
        arm = 1'b0;
        check({tag, "_busy_armed"}, busy, 1);

        c = 0;
        while (!ts_valid && c < 40) begin
            junk  = {$urandom, $urandom};
            tap_q = (c == k) ? pat : (junk & ~64'h1);
            arm   = (c == 1);
            tick();
            c++;
        end
        arm = 1'b0;
        check({tag, "_latency"}, c, elat);
        check({tag, "_valid"},   ts_valid, 1);
        check({tag, "_coarse"},  ts_coarse, ec);
        check({tag, "_fine"},    ts_fine, ef);
        check({tag, "_timeout"}, ts_timeout, eto);

        // Outputs must hold while the consumer stalls.
        for (int i = 0; i < d; i++) begin
            ts_ready = 1'b0;
            arm      = 1'b1;
            tap_q    = {$urandom, $urandom};
            tick();
            check({tag, "_hold_valid"},  ts_valid, 1);
            check({tag, "_hold_coarse"}, ts_coarse, ec);
            check({tag, "_hold_fine"},   ts_fine, ef);
            check({tag, "_hold_to"},     ts_timeout, eto);
        end
        arm      = 1'b0;
        ts_ready = 1'b1;
        tick();
        ts_ready = 1'b0;
        check({tag, "_xfer_valid"}, ts_valid, 0);
        check({tag, "_xfer_clr"},   line_clr, 1);

        // Drain: IDLE is reached exactly two cycles after the first zero cycle.
        c = 0;
        while (busy && c < 20) begin
            tap_q = (c < nz) ? ({$urandom, $urandom} | 64'h0000_0100_0000_0000) : '0;
            arm   = $urandom_range(0, 1) == 1;
            tick();
            c++;
            if (busy) check({tag, "_clr_line"}, line_clr, 1);
        end
        arm   = 1'b0;
        tap_q = '0;
        check({tag, "_clr_cycles"}, c, nz + 2);
        check({tag, "_idle_line"},  line_clr, 0);
        tick();
        check({tag, "_idle_busy"},  busy, 0);

        $display("txn %s: coarse=%0d fine=%0d timeout=%0d stall=%0d drain=%0d",
                 tag, ec, ef, eto, d, nz);
    endtask

    typedef struct {
        logic [63:0] tap;
        int          hit_k;
        int          rdy_dly;
        int          n_nz;
        int          exp_coarse;
        int          exp_fine;
        bit          exp_to;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        rst      = 1'b1;
        arm      = 1'b1;
        tap_q    = '1;
        ts_ready = 1'b0;

        // Directed vectors; hit_k beyond TIMEOUT means no hit at all.
        vecs[0] = '{64'h0000_0000_0000_00FF,  4, 0, 0,  4,  8, 1'b0,  6};
        vecs[1] = '{64'h0000_0000_0000_0F0B,  0, 1, 1,  0,  7, 1'b0,  2};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF,  9, 5, 3,  9, 64, 1'b0, 11};
        vecs[3] = '{64'h0000_0000_0000_0000, 99, 2, 0, 10,  0, 1'b1, 11};
        vecs[4] = '{64'h8000_0000_0000_0001, 10, 0, 2, 10,  2, 1'b0, 12};
        vecs[5] = '{64'h5555_5555_5555_5555,  1, 3, 0,  1, 32, 1'b0,  3};

        tick();
        tick();
        check_reset_vals("reset_hold");
        rst   = 1'b0;
        arm   = 1'b0;
        tap_q = '0;
        tick();
        check_reset_vals("reset_release");

        for (int i = 0; i < 6; i++) begin
            measure($sformatf("vec%0d", i), vecs[i].tap, vecs[i].hit_k, vecs[i].rdy_dly,
                    vecs[i].n_nz, vecs[i].exp_coarse, vecs[i].exp_fine,
                    vecs[i].exp_to, vecs[i].exp_lat);
        end

        // Randomized measurements against a transaction-level model:
        // a hit no later than TIMEOUT reports its ARMED cycle index and the
        // ones count two cycles later; otherwise the timeout reports TIMEOUT
        // one cycle after the counter reaches it.
        for (int r = 0; r < 25; r++) begin
            logic [63:0] pat;
            int k, d, nz, ec, ef, elat;
            bit eto;
            pat = {$urandom, $urandom} | 64'h1;
            k   = $urandom_range(0, 13);
            d   = $urandom_range(0, 4);
            nz  = $urandom_range(0, 3);
            if (k <= TMO) begin
                ec = k; ef = $countones(pat); eto = 1'b0; elat = k + 2;
            end else begin
                ec = TMO; ef = 0; eto = 1'b1; elat = TMO + 1;
            end
            measure($sformatf("rnd%0d", r), pat, k, d, nz, ec, ef, eto, elat);
        end

        // Reset while ARMED, with arm asserted alongside reset.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        arm = 1'b1;
        tick();
        rst = 1'b0;
        arm = 1'b0;
        check_reset_vals("rst_armed");
        tick();
        check("rst_armed_arm_ignored", busy, 0);
        $display("txn rst_armed: reset during ARMED");

        // Reset while a timestamp is pending in OUTPUT.
        begin
            int c;
            arm = 1'b1;
            tick();
            arm = 1'b0;
            c = 0;
            while (!ts_valid && c < 40) begin
                tap_q = (c == 2) ? 64'h0000_0000_0000_000F : '0;
                tick();
                c++;
            end
            tap_q = '0;
            check("rst_output_pending", ts_valid, 1);
            check("rst_output_fine", ts_fine, 4);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check_reset_vals("rst_output");
            tick();
            check("rst_output_idle", busy, 0);
            $display("txn rst_output: reset with timestamp pending");
        end

        // Normal operation resumes after the reset.
        measure("post_rst", 64'h0000_0000_0000_0007, 3, 0, 0, 3, 3, 1'b0, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
